pipe_stage_elastic: RTL and testbench

Parametrised elastic ID/EX-style pipeline stage register for the pipelined RV32 core. It replaces fixed flop-per-signal stage registers with a 2-entry skid buffer carrying a packed control bundle and a data bundle under valid/ready handshakes. It supports full throughput, backpressure from downstream, and flush (bubble insertion) for branch/jump redirects. It is instantiated between decode and execute, and is reusable for EX/MEM and MEM/WB.

---
 rtl/riscv_pipe_pkg.sv | 32 +++
 rtl/pipe_skid_slot.sv | 36 +++
 rtl/pipe_stage_elastic.sv | 123 ++++++++++++
 tb/tb_pipe_stage_elastic.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Types and constants shared by the pipelined RV32 stage registers:
// control-bundle layout, default bundle widths and the elastic-stage state encoding.
package riscv_pipe_pkg;

  localparam int RESULTSRC_W = 2;
  localparam int ALUCTRL_W   = 3;

  // Bit offsets of each field inside the packed control bundle (LSB = 0)
  localparam int ALUSRC_OFS    = 0;
  localparam int ALUCTRL_OFS   = 1;
  localparam int BRANCH_OFS    = ALUCTRL_OFS + ALUCTRL_W;
  localparam int JUMP_OFS      = BRANCH_OFS + 1;
  localparam int MEMWRITE_OFS  = JUMP_OFS + 1;
  localparam int RESULTSRC_OFS = MEMWRITE_OFS + 1;
  localparam int REGWRITE_OFS  = RESULTSRC_OFS + RESULTSRC_W;

  typedef struct packed {
    logic                   reg_write;
    logic [RESULTSRC_W-1:0] result_src;
    logic                   mem_write;
    logic                   jump;
    logic                   branch;
    logic [ALUCTRL_W-1:0]   alu_ctrl;
    logic                   alu_src;
  } ctrl_bundle_t;

  localparam int CTRL_W_DEF = $bits(ctrl_bundle_t);
  localparam int DATA_W_DEF = 96;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} stage_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// One storage slot of the elastic stage: valid bit plus payload register.
// Clear only drops the valid bit so the payload keeps its last value.
module pipe_skid_slot
  import riscv_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic         vld_o,
  output logic [W-1:0] q_o
);

  logic         vld_q;
  logic [W-1:0] pl_q;

  // Clear wins over load so a flush always empties the slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= 1'b0;
      pl_q  <= '0;
    end else if (clr_i) begin
      vld_q <= 1'b0;
    end else if (load_i) begin
      vld_q <= 1'b1;
      pl_q  <= d_i;
    end
  end

  assign vld_o = vld_q;
  assign q_o   = pl_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: 2-entry skid buffer (main + skid slot) with flush.
// Optional perf counters (stall/bubble/flush) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_elastic
  import riscv_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
`endif
  output logic [DATA_W-1:0] out_data
);

  localparam int PL_W = CTRL_W + DATA_W;

  stage_state_e state_q, state_d;
  logic main_ld, main_clr, main_sel_skid, skid_ld, skid_clr;
  logic main_vld, skid_vld, in_fire, out_fire;
  logic [PL_W-1:0] main_q, skid_q, main_d;

  // in_ready comes straight from the skid valid flop: no out_ready -> in_ready path
  assign in_ready  = !skid_vld;
  assign out_valid = main_vld;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    main_ld       = 1'b0;
    main_clr      = 1'b0;
    main_sel_skid = 1'b0;
    skid_ld       = 1'b0;
    skid_clr      = 1'b0;
    case (state_q)
      ST_EMPTY: if (in_fire) begin
        state_d = ST_ONE;
        main_ld = 1'b1;
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire) begin
          state_d = ST_TWO;
          skid_ld = 1'b1;
        end else if (out_fire) begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
        end
      end
      ST_TWO: if (out_fire) begin
        state_d       = ST_ONE;
        main_ld       = 1'b1;
        main_sel_skid = 1'b1;
        skid_clr      = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
    // Redirect: everything held or offered this cycle is dropped
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
      main_ld  = 1'b0;
      skid_ld  = 1'b0;
    end
  end

  assign main_d = main_sel_skid ? skid_q : {in_ctrl, in_data};

  pipe_skid_slot #(.W(PL_W)) u_main (
    .clk(clk), .reset(reset), .load_i(main_ld), .clr_i(main_clr),
    .d_i(main_d), .vld_o(main_vld), .q_o(main_q)
  );

  pipe_skid_slot #(.W(PL_W)) u_skid (
    .clk(clk), .reset(reset), .load_i(skid_ld), .clr_i(skid_clr),
    .d_i({in_ctrl, in_data}), .vld_o(skid_vld), .q_o(skid_q)
  );

  // Bubbles carry all-zero control so they never write state downstream
  assign out_ctrl = main_vld ? main_q[PL_W-1:DATA_W] : '0;
  assign out_data = main_q[DATA_W-1:0];

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, bubble_q, flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (out_valid && !out_ready && stall_q != '1) stall_q  <= stall_q + CNT_W'(1);
      if (!out_valid && bubble_q != '1)             bubble_q <= bubble_q + CNT_W'(1);
      if (flush && flush_q != '1)                   flush_q  <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: a queue scoreboard models the 2-entry
// FIFO and is compared against the DUT on every falling clock edge.
module tb_pipe_stage_elastic;

  localparam int CTRL_W = 10;
  localparam int DATA_W = 96;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
    .out_data(out_data)
  );

  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  int     pops   = 0;
  longint m_stall = 0, m_bubble = 0, m_flush = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare, then advance the model by this cycle's handshakes
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      m_stall = 0; m_bubble = 0; m_flush = 0;
    end else begin
      logic e_vld, e_rdy;
      ent_t h;
      e_vld = (sb.size() > 0);
      e_rdy = (sb.size() < 2);
      check("out_valid", 128'(out_valid), 128'(e_vld));
      check("in_ready", 128'(in_ready), 128'(e_rdy));
      if (e_vld) begin
        h = sb[0];
        check("out_ctrl", 128'(out_ctrl), 128'(h.c));
        check("out_data", 128'(out_data), 128'(h.d));
      end else begin
        check("bubble_ctrl", 128'(out_ctrl), 128'(0));
      end
`ifdef PIPE_STAGE_PERF_EN
      check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
      check("bubble_cnt", 128'(bubble_cnt), 128'(m_bubble));
      check("flush_cnt", 128'(flush_cnt), 128'(m_flush));
`endif
      if (e_vld && !out_ready) m_stall++;
      if (!e_vld) m_bubble++;
      if (flush) m_flush++;
      if (e_vld && out_ready) begin
        void'(sb.pop_front());
        pops++;
      end
      if (flush) sb.delete();
      else if (in_valid && e_rdy) begin
        h.c = in_ctrl;
        h.d = in_data;
        sb.push_back(h);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    int p0;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drv(1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    #1 reset = 1'b0;
    cyc();

    // Streaming at full rate
    p0 = pops;
    drv(1'b1, 10'h3FF, 96'h1); cyc();
    drv(1'b1, 10'h3FF, 96'h2); cyc();
    drv(1'b1, 10'h3FF, 96'h3); cyc();
    drv(1'b0, '0, '0); cyc(); cyc();
    check("stream_count", 128'(pops - p0), 128'(3));

    // Backpressure fills both slots, then drains in order
    p0 = pops;
    out_ready = 1'b0;
    drv(1'b1, 10'h155, 96'h11); cyc();
    drv(1'b1, 10'h2AA, 96'h22); cyc();
    drv(1'b0, '0, '0);
    check("two_in_ready", 128'(in_ready), 128'(0));
    cyc();
    out_ready = 1'b1; cyc(); cyc(); cyc();
    check("drain_count", 128'(pops - p0), 128'(2));

    // Flush while TWO with a new entry offered
    p0 = pops;
    out_ready = 1'b0;
    drv(1'b1, 10'h0F0, 96'h44); cyc();
    drv(1'b1, 10'h00F, 96'h55); cyc();
    drv(1'b1, 10'h333, 96'h33); flush = 1'b1; cyc();
    flush = 1'b0; drv(1'b0, '0, '0);
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_out_ctrl", 128'(out_ctrl), 128'(0));
    check("flush_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1; cyc(); cyc();
    check("flush_no_output", 128'(pops - p0), 128'(0));

    // Fill one, then 8 cycles of simultaneous in/out fire
    p0 = pops;
    for (int i = 0; i < 9; i++) begin
      drv(1'b1, CTRL_W'(i + 1), DATA_W'(32'h100 + i));
      cyc();
    end
    drv(1'b0, '0, '0); cyc(); cyc();
    check("steady_count", 128'(pops - p0), 128'(9));

    // Random handshakes
    for (int i = 0; i < 60; i++) begin
      drv(1'($urandom), CTRL_W'($urandom), {$urandom, $urandom, $urandom});
      out_ready = 1'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      cyc();
    end
    flush = 1'b0; drv(1'b0, '0, '0); out_ready = 1'b1;
    repeat (4) cyc();
    check("random_drained", 128'(sb.size()), 128'(0));

    // Stall for 5 cycles, flush, then idle
    out_ready = 1'b0;
    drv(1'b1, 10'h1C3, 96'hABC); cyc();
    drv(1'b0, '0, '0);
    repeat (4) cyc();
    flush = 1'b1; cyc();
    flush = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();

    // Asynchronous reset mid-transfer
    out_ready = 1'b0;
    drv(1'b1, 10'h3C3, 96'hDEAD_BEEF); cyc();
    drv(1'b0, '0, '0); cyc();
    check("pre_arst_valid", 128'(out_valid), 128'(1));
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_out_ctrl", 128'(out_ctrl), 128'(0));
    check("arst_out_data", 128'(out_data), 128'(0));
    check("arst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #2 reset = 1'b0;
    out_ready = 1'b1;
    drv(1'b1, 10'h201, 96'h77); cyc();
    drv(1'b0, '0, '0); cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
